mux_nx1_barrido: RTL

Parametrised N-channel, W-bit registered multiplexer with two selection modes: manual selection from an index input, and automatic round-robin scanning paced by an internal prescaler. It generalises the fixed two-input selector used in the display and data paths. Typical uses are driving time-multiplexed outputs such as digit scanning, and registered data selection between datapath sources. Outputs are the selected data word, the active channel index, and a one-cycle channel-change strobe.

---
 rtl/mux_nx1_barrido.sv | 98 +++++++++
 1 files changed

// File: rtl/mux_nx1_barrido.sv
// N-channel, W-bit registered multiplexer with manual index selection or prescaled round-robin scan.
// Optional macro MUX_BLANKING_EN inserts one blank (all-zero) output cycle on every channel change.
module mux_nx1_barrido #(
    parameter int N   = 4,
    parameter int W   = 4,
    parameter int DIV = 50000,
    localparam int SELW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              modo,
    input  logic              habilitar,
    input  logic [SELW-1:0]   sel_manual,
    input  logic [N*W-1:0]    datos,
    output logic [W-1:0]      y,
    output logic [SELW-1:0]   canal,
    output logic              cambio
);

    localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
    localparam logic [SELW-1:0] LAST_CH    = SELW'(N - 1);
    localparam logic [SELW:0]   N_LIMIT    = (SELW + 1)'(N);

    logic [PW-1:0]   presc_q, presc_d;
    logic [SELW-1:0] canal_q, canal_d;
    logic [W-1:0]    y_q, y_d;
    logic            cambio_q, cambio_d;
    logic            tick;
    logic            selValida;

    logic [W-1:0]    chan [N];

    for (genvar k = 0; k < N; k++) begin : g_chan
        assign chan[k] = datos[k*W +: W];
    end

    assign selValida = ({1'b0, sel_manual} < N_LIMIT);

    // Prescaler and channel index only move while enabled; manual mode keeps the prescaler cleared
    // so a later switch to scan waits a full DIV period before the first advance.
    always_comb begin
        presc_d = presc_q;
        canal_d = canal_q;
        tick    = 1'b0;
        if (habilitar) begin
            if (modo) begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick    = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                if (tick) begin
                    canal_d = (canal_q == LAST_CH) ? '0 : canal_q + 1'b1;
                end
            end else begin
                presc_d = '0;
                if (selValida) begin
                    canal_d = sel_manual;
                end
            end
        end
    end

    // y follows the channel that canal will hold after this edge, so data and index stay aligned.
    always_comb begin
        cambio_d = (canal_d != canal_q);
`ifdef MUX_BLANKING_EN
        if (cambio_d) begin
            y_d = '0;
        end else begin
            y_d = chan[canal_d];
        end
`else
        y_d = chan[canal_d];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            canal_q  <= '0;
            y_q      <= '0;
            cambio_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            canal_q  <= canal_d;
            y_q      <= y_d;
            cambio_q <= cambio_d;
        end
    end

    assign y      = y_q;
    assign canal  = canal_q;
    assign cambio = cambio_q;

endmodule
